// File: rtl/sd_dat_rx_crc_check_pkg.sv
// Shared types and constants for the SD DAT0 receive / CRC16 check block.
// Used by the top module sd_dat_rx_crc_check and by its serial CRC sub-module.
package sd_rx_pkg;

    // Receive FSM: start bit seen -> data bits -> CRC field -> end bit -> report
    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CRC,
        ENDB,
        DONE
    } rx_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    // One serial CRC16-CCITT step: feedback is the incoming bit XOR the register MSB
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_dat_rx_crc_check_if.sv
// Bus between an SD DAT0 sampler (master) and the receive/CRC checker (slave).
// The capture outputs exist only when SD_RX_CRC_CAPTURE_EN is defined.
interface sd_dat_rx_crc_check_if;

    logic       sample_en;
    logic       dat_in;
    logic       abort;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       busy;
    logic       block_done;
    logic       crc_ok;
    logic       crc_err;
    logic       end_err;
`ifdef SD_RX_CRC_CAPTURE_EN
    logic [15:0] calc_crc;
    logic [15:0] rx_crc;
`endif

    modport master (
        output sample_en, dat_in, abort,
        input  byte_out, byte_valid, busy, block_done, crc_ok, crc_err, end_err
`ifdef SD_RX_CRC_CAPTURE_EN
        , calc_crc, rx_crc
`endif
    );

    modport slave (
        input  sample_en, dat_in, abort,
        output byte_out, byte_valid, busy, block_done, crc_ok, crc_err, end_err
`ifdef SD_RX_CRC_CAPTURE_EN
        , calc_crc, rx_crc
`endif
    );

endinterface

// File: rtl/sd_dat_rx_crc_check_crc16.sv
// Bit-serial CRC16-CCITT accumulator (poly 0x1021, init 0x0000).
// clear has priority over shift_en; the value holds whenever neither is set.
module crc16_ccitt_serial
    import sd_rx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    // CRC register: cleared at block start, advanced once per qualified data bit
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses <= so every flop sees pre-edge values, independent of block ordering.
        if (!n_rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (shift_en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_dat_rx_crc_check.sv
// SD DAT0 single-line block receiver: assembles BLOCK_BYTES data bytes MSB first,
// checks the trailing CRC16 and end bit, and reports block status.
// Optional build macro SD_RX_CRC_CAPTURE_EN exposes the computed and received CRCs.
module sd_dat_rx_crc_check
    import sd_rx_pkg::*;
#(
    parameter int BLOCK_BYTES = 512
) (
    input logic                  clk,
    input logic                  n_rst,
    sd_dat_rx_crc_check_if.slave sio
);

    localparam int                DATA_BITS = BLOCK_BYTES * 8;
    localparam int                CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  LAST_CRC  = CNT_W'(15);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [6:0]       byte_sr;
    logic [7:0]       byte_q;
    logic             byte_valid_q;
    logic [15:0]      rx_crc;
    logic [15:0]      calc_crc;
    logic             crc_ok_q;
    logic             crc_err_q;
    logic             end_err_q;
    logic             busy_c;
    logic             done_c;

    // Abort outranks sample_en in every active state, so a cancelled bit is never consumed.
    logic take;
    logic start_bit;
    logic data_bit;
    logic crc_bit;
    logic end_bit;
    logic last_data;
    logic last_crc;

    assign take      = sio.sample_en & ~sio.abort;
    assign start_bit = (state == IDLE) & sio.sample_en & ~sio.dat_in;
    assign data_bit  = (state == DATA) & take;
    assign crc_bit   = (state == CRC)  & take;
    assign end_bit   = (state == ENDB) & take;
    assign last_data = data_bit & (bit_cnt == LAST_DATA);
    assign last_crc  = crc_bit  & (bit_cnt == LAST_CRC);

    crc16_ccitt_serial u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (start_bit),
        .shift_en (data_bit),
        .bit_in   (sio.dat_in),
        .crc      (calc_crc)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave one unassigned and infer a latch.
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: if (start_bit) state_nxt = DATA;
            DATA: begin
                busy_c = 1'b1;
                if (sio.abort)      state_nxt = IDLE;
                else if (last_data) state_nxt = CRC;
            end
            CRC: begin
                busy_c = 1'b1;
                if (sio.abort)     state_nxt = IDLE;
                else if (last_crc) state_nxt = ENDB;
            end
            ENDB: begin
                busy_c = 1'b1;
                if (sio.abort)    state_nxt = IDLE;
                else if (end_bit) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter: counts data bits, then is reused for the 16 CRC bits
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
        end else if (start_bit || last_data || last_crc) begin
            bit_cnt <= '0;
        end else if (data_bit || crc_bit) begin
            bit_cnt <= bit_cnt + CNT_ONE;
        end
    end

    // Byte assembly: the 8th bit of each byte loads byte_out and raises byte_valid for one cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_sr      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            if (data_bit) begin
                byte_sr <= {byte_sr[5:0], sio.dat_in};
                if (bit_cnt[2:0] == 3'd7) begin
                    byte_q       <= {byte_sr, sio.dat_in};
                    byte_valid_q <= 1'b1;
                end
            end
        end
    end

    // Received CRC field, MSB first; holds after the field until the next start bit
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_crc <= CRC16_INIT;
        end else if (start_bit) begin
            rx_crc <= CRC16_INIT;
        end else if (crc_bit) begin
            rx_crc <= {rx_crc[14:0], sio.dat_in};
        end
    end

    // Status flags resolve on the end bit so they are already valid in the DONE cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
        end else if (start_bit) begin
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
        end else if (end_bit) begin
            crc_err_q <= (rx_crc != calc_crc);
            end_err_q <= ~sio.dat_in;
            crc_ok_q  <= (rx_crc == calc_crc) & sio.dat_in;
        end
    end

    assign sio.byte_out   = byte_q;
    assign sio.byte_valid = byte_valid_q;
    assign sio.busy       = busy_c;
    assign sio.block_done = done_c;
    assign sio.crc_ok     = crc_ok_q;
    assign sio.crc_err    = crc_err_q;
    assign sio.end_err    = end_err_q;
`ifdef SD_RX_CRC_CAPTURE_EN
    assign sio.calc_crc   = calc_crc;
    assign sio.rx_crc     = rx_crc;
`endif

endmodule

// File: tb/tb_sd_dat_rx_crc_check.sv
// Scoreboard bench for sd_dat_rx_crc_check (BLOCK_BYTES = 512).
// The reference CRC is a polynomial long division of the message with 16 appended zeros.
module tb_sd_dat_rx_crc_check;

    localparam int BB = 512;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    sd_dat_rx_crc_check_if sio ();

    sd_dat_rx_crc_check #(.BLOCK_BYTES(BB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .sio   (sio.slave)
    );

    typedef struct {
        logic        ok;
        logic        cerr;
        logic        eerr;
        logic [15:0] calc;
        logic [15:0] rx;
    } blk_exp_t;

    logic [7:0] exp_bytes[$];
    blk_exp_t   exp_blks[$];
    logic [7:0] blk[BB];
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Remainder of (message * x^16) divided by x^16 + x^12 + x^5 + 1
    function automatic logic [15:0] ref_crc();
        logic [16:0] rem;
        logic        b;
        rem = '0;
        for (int i = 0; i < BB * 8 + 16; i++) begin
            b   = (i < BB * 8) ? blk[i / 8][7 - (i % 8)] : 1'b0;
            rem = {rem[15:0], b};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int max_gap);
        int gaps;
        gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        sio.sample_en = 1'b0;
        repeat (gaps) tick();
        sio.sample_en = 1'b1;
        sio.dat_in    = b;
        tick();
        sio.sample_en = 1'b0;
        sio.dat_in    = 1'b1;
    endtask

    task automatic send_bytes(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            exp_bytes.push_back(blk[i]);
            for (int k = 7; k >= 0; k--) send_bit(blk[i][k], max_gap);
        end
    endtask

    task automatic send_block(input logic [15:0] crc_field, input logic endb, input int max_gap);
        blk_exp_t    e;
        logic [15:0] model;
        model  = ref_crc();
        e.ok   = (crc_field == model) && endb;
        e.cerr = (crc_field != model);
        e.eerr = !endb;
        e.calc = model;
        e.rx   = crc_field;
        exp_blks.push_back(e);
        send_bit(1'b0, max_gap);
        check("busy_after_start", 32'(sio.busy), 32'd1);
        check("flags_clear_on_start", {29'd0, sio.crc_ok, sio.crc_err, sio.end_err}, 32'd0);
        send_bytes(BB, max_gap);
        for (int i = 15; i >= 0; i--) send_bit(crc_field[i], max_gap);
        send_bit(endb, max_gap);
        repeat (3) tick();
        check("flags_hold", {29'd0, sio.crc_ok, sio.crc_err, sio.end_err}, {29'd0, e.ok, e.cerr, e.eerr});
        check("busy_after_done", 32'(sio.busy), 32'd0);
        check("bytes_drained", 32'(exp_bytes.size()), 32'd0);
        check("block_reported", 32'(exp_blks.size()), 32'd0);
    endtask

    // Monitor: compares every byte_valid / block_done against the scoreboard queues
    initial begin
        blk_exp_t e;
        forever begin
            @(negedge clk);
            if (sio.byte_valid) begin
                if (exp_bytes.size() == 0) check("byte_valid_expected", 32'(sio.byte_valid), 32'd0);
                else                       check("byte_out", 32'(sio.byte_out), 32'(exp_bytes.pop_front()));
            end
            if (sio.block_done) begin
                if (exp_blks.size() == 0) begin
                    check("block_done_expected", 32'(sio.block_done), 32'd0);
                end else begin
                    e = exp_blks.pop_front();
                    check("crc_ok", 32'(sio.crc_ok), 32'(e.ok));
                    check("crc_err", 32'(sio.crc_err), 32'(e.cerr));
                    check("end_err", 32'(sio.end_err), 32'(e.eerr));
                    check("busy_in_done", 32'(sio.busy), 32'd0);
`ifdef SD_RX_CRC_CAPTURE_EN
                    check("calc_crc", 32'(sio.calc_crc), 32'(e.calc));
                    check("rx_crc", 32'(sio.rx_crc), 32'(e.rx));
`endif
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sio.sample_en = 1'b0;
        sio.dat_in    = 1'b1;
        sio.abort     = 1'b0;
        n_rst         = 1'b0;
        repeat (3) tick();
        check("rst_byte_out", 32'(sio.byte_out), 32'd0);
        check("rst_outputs", {27'd0, sio.byte_valid, sio.busy, sio.block_done, sio.crc_ok, sio.crc_err, sio.end_err}, 32'd0);
        n_rst = 1'b1;
        repeat (2) tick();

        // All-zero block, CRC 0x0000, end bit 1
        foreach (blk[i]) blk[i] = 8'h00;
        send_block(16'h0000, 1'b1, 0);
        repeat (2) tick();

        // All-0xFF block with its correct CRC, then with a corrupted CRC
        foreach (blk[i]) blk[i] = 8'hFF;
        send_block(16'h7FA1, 1'b1, 0);
        repeat (2) tick();
        send_block(16'h7FA0, 1'b1, 0);
        repeat (2) tick();

        // Random data, correct CRC, bad end bit
        foreach (blk[i]) blk[i] = 8'($urandom);
        send_block(ref_crc(), 1'b0, 0);
        repeat (2) tick();

        // Abort after 100 bytes (abort wins over a simultaneous sample), then a clean zero block
        foreach (blk[i]) blk[i] = 8'($urandom);
        send_bit(1'b0, 0);
        send_bytes(100, 0);
        sio.abort     = 1'b1;
        sio.sample_en = 1'b1;
        sio.dat_in    = 1'b0;
        tick();
        sio.abort     = 1'b0;
        sio.sample_en = 1'b0;
        sio.dat_in    = 1'b1;
        check("busy_after_abort", 32'(sio.busy), 32'd0);
        check("flags_after_abort", {29'd0, sio.crc_ok, sio.crc_err, sio.end_err}, 32'd0);
        repeat (2) tick();
        check("abort_bytes_drained", 32'(exp_bytes.size()), 32'd0);
        foreach (blk[i]) blk[i] = 8'h00;
        send_block(16'h0000, 1'b1, 0);
        repeat (2) tick();

        // Reset in the middle of the CRC field
        foreach (blk[i]) blk[i] = 8'($urandom);
        send_bit(1'b0, 0);
        send_bytes(BB, 0);
        for (int i = 15; i >= 8; i--) send_bit(1'b1, 0);
        check("busy_mid_crc", 32'(sio.busy), 32'd1);
        n_rst = 1'b0;
        #1;
        check("async_rst_byte_out", 32'(sio.byte_out), 32'd0);
        check("async_rst_outputs", {27'd0, sio.byte_valid, sio.busy, sio.block_done, sio.crc_ok, sio.crc_err, sio.end_err}, 32'd0);
        tick();
        n_rst         = 1'b1;
        sio.sample_en = 1'b1;
        sio.dat_in    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("busy_idle_ones", 32'(sio.busy), 32'd0);
        end
        sio.sample_en = 1'b0;
        repeat (2) tick();

        // Random data with random 0-5 cycle gaps between sampled bits
        foreach (blk[i]) blk[i] = 8'($urandom);
        send_block(ref_crc(), 1'b1, 5);
        repeat (4) tick();

        check("final_bytes_empty", 32'(exp_bytes.size()), 32'd0);
        check("final_blocks_empty", 32'(exp_blks.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_dat_rx_crc_check.md
SD_DAT_RX_CRC_CHECK -- requirements
Module: sd_dat_rx_crc_check

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, giving data bytes per block (range 1..4096).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sample_en  input  1  one-cycle strobe qualifying dat_in as one SD bit.
REQ-005 SHALL have port dat_in  input  1  serial SD DAT0 bit, MSB first.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the block in progress.
REQ-007 SHALL have port byte_out  output  8  last assembled data byte.
REQ-008 SHALL have port byte_valid  output  1  one-cycle pulse when byte_out updates.
REQ-009 SHALL have port busy  output  1  high from start bit through end-bit evaluation.
REQ-010 SHALL have port block_done  output  1  one-cycle pulse at block completion.
REQ-011 SHALL have port crc_ok, crc_err, end_err  output  1 each  block status flags.

Function
REQ-012 SHALL implement FSM states IDLE, DATA, CRC, ENDB, DONE; bits are consumed only on cycles with sample_en=1.
REQ-013 IDLE: sample_en & dat_in=0 (start bit) -> DATA; CRC register cleared to 0x0000; bit counter cleared; status flags cleared; dat_in=1 -> remain IDLE.
REQ-014 DATA: each sampled bit updates CRC16-CCITT (poly 0x1021): fb = dat_in ^ crc[15]; crc = {crc[14:0],1'b0} ^ (fb ? 0x1021 : 0).
REQ-015 DATA: bits shift MSB-first into a byte register; on the 8th bit byte_out loads and byte_valid pulses the following cycle.
REQ-016 DATA -> CRC after BLOCK_BYTES*8 sampled bits; counter width clog2(BLOCK_BYTES*8+1).
REQ-017 CRC: 16 sampled bits shift MSB-first into rx_crc; computed CRC frozen; then -> ENDB.
REQ-018 ENDB: next sampled bit is the end bit -> DONE.
REQ-019 DONE (one cycle): block_done=1; crc_err = (rx_crc != calc_crc); end_err = (end bit == 0); crc_ok = !crc_err & !end_err; -> IDLE.
REQ-020 Status flags SHALL hold until the next start bit or reset.
REQ-021 abort=1 in any non-IDLE state -> IDLE next cycle; no block_done, no byte_valid, flags stay 0; abort has priority over sample_en.
REQ-022 sample_en gaps of any length SHALL not alter state, counters or CRC.
REQ-023 busy SHALL be high in DATA, CRC, ENDB; low in IDLE and DONE.

Reset
REQ-024 n_rst=0 SHALL asynchronously force IDLE, CRC=0x0000, rx_crc=0x0000, counters 0, byte_out=0x00, all 1-bit outputs 0, including mid-block.

Configuration
REQ-025 With SD_RX_CRC_CAPTURE_EN defined, SHALL add outputs calc_crc[15:0] and rx_crc[15:0], valid from DONE until next start bit; without it these ports and no extra logic exist, and all other behaviour is identical.

Structure
REQ-026 Package sd_rx_pkg SHALL hold the FSM state enum, CRC16_POLY=16'h1021 and CRC16_INIT=16'h0000.
REQ-027 CRC update SHALL be a sub-module crc16_ccitt_serial (clk, n_rst, clear, shift_en, bit_in, crc[15:0]).

Verification
REQ-028 BLOCK_BYTES=512, all 0x00, CRC 0x0000, end 1 -> 512 byte_valid pulses, block_done, crc_ok=1.
REQ-029 512 bytes 0xFF, CRC 0x7FA1, end 1 -> crc_ok=1; same with CRC 0x7FA0 -> crc_err=1, crc_ok=0.
REQ-030 Valid block with end bit 0 -> end_err=1, crc_err=0, crc_ok=0.
REQ-031 abort after 100 bytes, then a valid 0x00 block -> no block_done for the first, crc_ok=1 for the second.
REQ-032 n_rst low mid-CRC field -> all outputs 0, IDLE; dat_in=1 with sample_en for 50 cycles -> busy stays 0.
REQ-033 Valid block with random 0-5 cycle sample_en gaps -> identical bytes and crc_ok=1.
